store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of buffered stores (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port MemWriteM, input, 1, store request from the Memory stage.
REQ-005 The block SHALL have port MemReadM, input, 1, load request from the Memory stage.
REQ-006 The block SHALL have port FenceM, input, 1, fence request from the Memory stage; drain all stores before proceeding.
REQ-007 The block SHALL have port DataAdrM, input, 32, byte address of the Memory-stage access.
REQ-008 The block SHALL have port WriteDataM, input, 32, store data.
REQ-009 The block SHALL have port MemReady, input, 1, data memory accepts the presented write this cycle.
REQ-010 The block SHALL have port MemWrite, output, 1, write valid toward data memory.
REQ-011 The block SHALL have port DataAdr, output, 32, write address toward data memory.
REQ-012 The block SHALL have port WriteData, output, 32, write data toward data memory.
REQ-013 The block SHALL have port StallSB, output, 1, stall request to the hazard unit (freezes F/D/E/M, bubbles W).
REQ-014 The block SHALL have port Empty, output, 1, high when no store is buffered.
REQ-015 The block SHALL have port Count, output, $clog2(DEPTH)+1, number of buffered stores.

Function
REQ-016 The block SHALL hold stores in a FIFO of DEPTH entries; each entry is a {32-bit address, 32-bit data} pair; stores drain in program order.
REQ-017 The block SHALL push the store in the same clock edge on which MemWriteM=1 and Count<DEPTH.
REQ-018 The block SHALL raise StallSB combinationally when MemWriteM=1 and Count=DEPTH.
REQ-019 The block SHALL NOT push on a full cycle, even if a pop occurs in that cycle; the store pushes on the next cycle.
REQ-020 The block SHALL drive MemWrite=1 whenever Count>0, with DataAdr and WriteData taken from the head entry.
REQ-021 The block SHALL pop the head on the edge on which MemWrite=1 and MemReady=1.
REQ-022 The block SHALL keep the head entry stable until it pops.
REQ-023 On a simultaneous push and pop with 0<Count<DEPTH, Count SHALL remain unchanged and both pointers SHALL advance.
REQ-024 With Count=0 and MemWriteM=1, the new store SHALL appear on the outputs at the earliest one cycle after the push edge; the buffer has no bypass.
REQ-025 Read and write pointers SHALL each be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-026 Full SHALL be Count=DEPTH and Empty SHALL be Count=0.
REQ-027 When MemReadM=1 and DataAdrM[31:2] equals the [31:2] address of any valid entry, the block SHALL raise StallSB combinationally; it SHALL release the stall in the cycle after the last matching entry pops. The block does no load forwarding.
REQ-028 Loads with no address match SHALL NOT stall, regardless of Count.
REQ-029 When FenceM=1 and Count>0, the block SHALL raise StallSB; StallSB SHALL drop in the cycle where Count=0.
REQ-030 StallSB SHALL be the OR of the full-store, load-hit and fence conditions and SHALL depend only on registered state and current M-stage inputs.
REQ-031 MemWriteM and MemReadM both high is illegal; the block SHALL treat the case as a store only.

Reset
REQ-032 While reset=1 at a rising edge, the block SHALL clear Count and both pointers and discard all entries, including any entry mid-drain.
REQ-033 From the first cycle after that edge until a new store pushes, the block SHALL drive MemWrite=0, StallSB=0, Empty=1 and Count=0.
REQ-034 The block SHALL NOT reset the entry storage; DataAdr and WriteData are don't-care while MemWrite=0.
REQ-035 A push requested in a reset cycle SHALL be dropped.

Verification
REQ-036 Scenario: MemReady=1, single store 0x2004/0x0000000A -> next cycle MemWrite=1, DataAdr=0x2004, WriteData=0xA; one cycle later Empty=1.
REQ-037 Scenario: MemReady=0, five back-to-back stores 0x100..0x110 (DEPTH=4) -> Count reaches 4, StallSB=1 on the 5th; after MemReady=1, writes emerge in order 0x100, 0x104, 0x108, 0x10C, 0x110.
REQ-038 Scenario: store 0x2004 buffered with MemReady=0, then load from 0x2006 -> StallSB=1; raising MemReady pops the entry and StallSB=0 the next cycle. A load from 0x2008 never stalls.
REQ-039 Scenario: three stores buffered, FenceM=1, MemReady=1 -> StallSB stays high exactly 3 cycles; Count goes 3, 2, 1, 0.
REQ-040 Scenario: with Count=2 and a push and pop in the same cycle -> Count stays 2; 8 such cycles wrap both pointers with data order preserved.
REQ-041 Scenario: reset=1 asserted with Count=3 mid-drain -> the cycle after the reset edge shows MemWrite=0, Count=0, Empty=1, and no stale entry is written afterwards.

Source files
------------

// File: rtl/store_buffer.sv
// Post-M-stage store buffer: a FIFO of {address, data} stores that drains to data
// memory in program order. It stalls the pipeline on full, on load hits and on fences.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWriteM,
  input  logic                   MemReadM,
  input  logic                   FenceM,
  input  logic [31:0]            DataAdrM,
  input  logic [31:0]            WriteDataM,
  input  logic                   MemReady,
  output logic                   MemWrite,
  output logic [31:0]            DataAdr,
  output logic [31:0]            WriteData,
  output logic                   StallSB,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage is never reset; a slot's contents only matter while it is counted.
  logic [31:0]   adr_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          load_hit;
  logic          store_stall;
  logic          fence_stall;
  logic [AW-1:0] off;

  assign full  = (count_q == CW'(DEPTH));
  assign Empty = (count_q == '0);
  assign Count = count_q;

  // Drain port is valid/ready: MemWrite is valid whenever an entry is held, the head
  // stays put while MemWrite=1, and it retires on any edge where MemWrite & MemReady.
  assign MemWrite  = ~Empty;
  assign DataAdr   = adr_mem[rd_ptr_q];
  assign WriteData = data_mem[rd_ptr_q];

  // A store+load combination is treated purely as a store.
  assign push = MemWriteM & ~full & ~reset;
  assign pop  = MemWrite & MemReady;

  assign store_stall = MemWriteM & full;
  assign fence_stall = FenceM & ~Empty;

  // Word-granular address compare against every counted entry.
  always_comb begin
    load_hit = 1'b0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (adr_mem[i][31:2] == DataAdrM[31:2])) begin
        load_hit = MemReadM & ~MemWriteM;
      end
    end
  end

  assign StallSB = store_stall | load_hit | fence_stall;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[wr_ptr_q]  <= DataAdrM;
      data_mem[wr_ptr_q] <= WriteDataM;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: stimulus pushes expected drain writes into a queue,
// a negedge monitor pops and compares every accepted memory write.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemReadM, FenceM, MemReady;
  logic [31:0] DataAdrM, WriteDataM;
  logic        MemWrite, StallSB, Empty;
  logic [31:0] DataAdr, WriteData;
  logic [2:0]  Count;

  logic [63:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .FenceM(FenceM), .DataAdrM(DataAdrM), .WriteDataM(WriteDataM),
    .MemReady(MemReady), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .StallSB(StallSB), .Empty(Empty), .Count(Count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: every accepted write must match the oldest expected store
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset && MemWrite && MemReady) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL drain_unexpected: got adr=%h data=%h, expected no write", DataAdr, WriteData);
      end else begin
        e = exp_q.pop_front();
        if ({DataAdr, WriteData} !== e) begin
          fails++;
          $display("FAIL drain_order: got adr=%h data=%h, expected adr=%h data=%h",
                   DataAdr, WriteData, e[63:32], e[31:0]);
        end
      end
    end
  end

  // driver / check tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a store, hold it through any stall, return one cycle after the push edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    MemWriteM = 1'b1; DataAdrM = a; WriteDataM = d;
    #1;
    while (StallSB && n < 50) begin
      tick();
      n++;
    end
    check("store_accept", 32'(n < 50), 32'd1);
    exp_q.push_back({a, d});
    tick();
    MemWriteM = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    #1;
    while (!Empty && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(Empty), 32'd1);
    check({name, "_sb"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; MemWriteM = 1'b0; MemReadM = 1'b0; FenceM = 1'b0;
    MemReady = 1'b0; DataAdrM = '0; WriteDataM = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_count", 32'(Count), 32'd0);
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_stall", 32'(StallSB), 32'd0);
    tick();

    // single store appears one cycle after its push edge, then drains
    MemReady = 1'b1;
    store(32'h2004, 32'h0000000A);
    check("single_memwrite", 32'(MemWrite), 32'd1);
    check("single_adr", DataAdr, 32'h2004);
    check("single_data", WriteData, 32'h0000000A);
    tick();
    check("single_empty", 32'(Empty), 32'd1);

    // fill to full, fifth store stalls, then drains in order
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    check("full_count", 32'(Count), 32'd4);
    MemWriteM = 1'b1; DataAdrM = 32'h110; WriteDataM = 32'hA4;
    #1;
    check("full_stall", 32'(StallSB), 32'd1);
    MemReady = 1'b1;
    store(32'h110, 32'hA4);
    wait_empty("full_drain");

    // load hit stalls until the matching entry drains; a miss never stalls
    MemReady = 1'b0;
    store(32'h2004, 32'h55);
    MemReadM = 1'b1; DataAdrM = 32'h2006;
    #1;
    check("load_hit_stall", 32'(StallSB), 32'd1);
    DataAdrM = 32'h2008;
    #1;
    check("load_miss_stall", 32'(StallSB), 32'd0);
    DataAdrM = 32'h2006;
    #1;
    check("load_hit_again", 32'(StallSB), 32'd1);
    MemReady = 1'b1;
    tick();
    check("load_release", 32'(StallSB), 32'd0);
    check("load_empty", 32'(Empty), 32'd1);
    MemReadM = 1'b0;

    // fence: three buffered stores give exactly three stall cycles
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h300 + 32'(4 * i), 32'hF0 + 32'(i));
    FenceM = 1'b1; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fence_count", 32'(Count), 32'(3 - i));
      check("fence_stall", 32'(StallSB), 32'(i < 3));
      tick();
    end
    FenceM = 1'b0;

    // steady push+pop at Count=2 for 8 cycles wraps both pointers
    MemReady = 1'b0;
    store(32'h400, 32'h11);
    store(32'h404, 32'h22);
    MemReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      MemWriteM = 1'b1; DataAdrM = 32'h500 + 32'(4 * i); WriteDataM = 32'hC0 + 32'(i);
      #1;
      check("pp_stall", 32'(StallSB), 32'd0);
      exp_q.push_back({DataAdrM, WriteDataM});
      tick();
      check("pp_count", 32'(Count), 32'd2);
    end
    MemWriteM = 1'b0;
    wait_empty("pp_drain");

    // reset mid-drain discards everything, including a store in the reset cycle
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h600 + 32'(4 * i), 32'hD0 + 32'(i));
    check("pre_rst_count", 32'(Count), 32'd3);
    MemReady = 1'b1; reset = 1'b1;
    MemWriteM = 1'b1; DataAdrM = 32'h700; WriteDataM = 32'hEE;
    tick();
    reset = 1'b0; MemWriteM = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_memwrite", 32'(MemWrite), 32'd0);
    check("mid_rst_count", 32'(Count), 32'd0);
    check("mid_rst_empty", 32'(Empty), 32'd1);
    check("mid_rst_stall", 32'(StallSB), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_count", 32'(Count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
